rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum grant duration in cycles; valid range 0..255; 0 disables the timeout.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: en  input  1  arbiter enable; gates new grants only.
REQ-005 Port: req  input  8  request vector; bit k = requester k; level-sensitive, held for the whole grant.
REQ-006 Port: done  input  1  single-cycle release pulse from the current owner.
REQ-007 Port: gnt  output  8  one-hot grant vector, registered; zero when no owner.
REQ-008 Port: gnt_idx  output  3  binary index of the current owner, registered; holds the last value while idle.
REQ-009 Port: busy  output  1  registered; high while a grant is active.
REQ-010 Port: timeout  output  1  registered one-cycle pulse on a forced release.

Function
REQ-011 FSM states: IDLE (no owner) and GRANT (one owner); state is registered.
REQ-012 Rotating pointer ptr (3 bits): the first requester examined in a scan.
REQ-013 Winner selection: first set bit of req, scanning ptr, ptr+1, ... 7, 0, ... ptr-1 with mod-8 wrap.
REQ-014 IDLE with en=1 and req!=0: next edge enters GRANT and loads gnt=onehot(winner), gnt_idx=winner, busy=1, hold_cnt=0.
REQ-015 IDLE with en=0 or req=0: remain in IDLE; gnt=0 and busy=0.
REQ-016 Latency: gnt is asserted on the first clock edge after the qualifying req is sampled.
REQ-017 GRANT: the 8-bit hold_cnt increments by 1 each cycle and saturates at 255.
REQ-018 Release conditions, checked in GRANT:
  - done=1.
  - req[gnt_idx]=0, i.e. the owner withdraws its request.
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, i.e. timeout.
REQ-019 On release: next edge enters IDLE with gnt=0, busy=0 and ptr=gnt_idx+1 (mod 8); gnt_idx is unchanged.
REQ-020 On release: timeout=1 for one cycle only if the timeout condition is the sole release cause; done or a withdrawn request take precedence.
REQ-021 With MAX_HOLD=N>0 and no other release: gnt stays high for exactly N cycles.
REQ-022 At least one IDLE cycle always separates consecutive grants; back-to-back grants are not allowed.
REQ-023 en falling during GRANT does not end the grant.
REQ-024 done asserted while in IDLE is ignored.
REQ-025 Changes to non-owner req bits during GRANT have no effect.
REQ-026 gnt has at most one bit set in every cycle.
REQ-027 If busy=1, then gnt[gnt_idx]=1.

Reset
REQ-028 While rst_n=0, immediately and independent of clk:
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=8'h00, gnt_idx=3'd0, busy=0, timeout=0.
REQ-029 Reset asserted mid-grant drops gnt immediately; the grant is not resumed after reset releases.
REQ-030 The first grant after reset release follows REQ-014 with ptr=0.

Structure
REQ-031 A shared package rr_arb_pkg holds the constants: N_REQ=8, IDX_W=3, CNT_W=8, and the state encodings IDLE=1'b0, GRANT=1'b1.
REQ-032 One combinational sub-module, rr_pick:
  - Inputs: req[7:0] and ptr[2:0].
  - Outputs: winner[2:0] and any.
  - Implementation: rotate req by ptr, fixed-priority scan from bit 0 upward, then add ptr back mod 8.
REQ-033 The top level contains only the FSM, ptr, hold_cnt and the output registers.

Verification
REQ-034 Reset: rst_n=0, then release with req=8'h00 -> gnt=8'h00, busy=0, gnt_idx=0, timeout=0.
REQ-035 Single requester from reset, req=8'h04:
  - next edge: gnt=8'h04, gnt_idx=2, busy=1.
  - done pulse: next edge gnt=8'h00, busy=0.
  - afterwards ptr=3.
REQ-036 Rotation, req=8'hFF held and done pulsed in each grant's first cycle -> gnt_idx sequence 0,1,2,...,7,0, with one IDLE cycle between grants.
REQ-037 Wrap, ptr=6 and req=8'h03 -> gnt=8'h01, gnt_idx=0.
REQ-038 Timeout, MAX_HOLD=4, req=8'h01 held, no done:
  - gnt=8'h01 for exactly 4 cycles.
  - timeout=1 for one cycle as gnt falls.
  - same run with done in the 4th cycle -> timeout stays 0.
REQ-039 Mid-grant reset, gnt=8'h10, then rst_n=0 between edges -> gnt=8'h00 and busy=0 immediately; after release with req=8'h10 -> gnt_idx=4 one cycle later.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants for the round-robin arbiter.
// Sizes and FSM state encodings.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin winner picker.
// Rotates req by ptr, scans upward, re-adds ptr.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_off;

    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: N_REQ];

    // Lowest set bit of the rotated vector is the closest requester to ptr
    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IDX_W'(i);
        end
    end

    assign any    = |req;
    assign winner = w_off + ptr;

endmodule

// File: rtl/rr_arbiter.sv
// Eight-way round-robin arbiter with hold timeout.
// One owner at a time, one idle cycle between grants.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    localparam logic             TO_EN     = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_hold;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_busy;
    logic             r_timeout;

    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic [N_REQ-1:0] w_onehot;
    logic             w_rel_done;
    logic             w_rel_wd;
    logic             w_rel_to;
    logic             w_release;
    logic             w_to_only;

    rr_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_win),
        .any    (w_any)
    );

    assign w_onehot   = N_REQ'(1) << w_win;
    assign w_rel_done = done;
    assign w_rel_wd   = ~req[r_gnt_idx];
    assign w_rel_to   = TO_EN && (r_hold == HOLD_LAST);
    assign w_release  = w_rel_done | w_rel_wd | w_rel_to;
    assign w_to_only  = w_rel_to & ~w_rel_done & ~w_rel_wd;

    // FSM, rotating pointer, hold counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (en && w_any) begin
                        r_state   <= GRANT;
                        r_gnt     <= w_onehot;
                        r_gnt_idx <= w_win;
                        r_busy    <= 1'b1;
                        r_hold    <= '0;
                    end else begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state   <= IDLE;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_ptr     <= r_gnt_idx + IDX_W'(1);
                        r_timeout <= w_to_only;
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed testbench for rr_arbiter.
// DUT built with MAX_HOLD=4.
module tb_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        en    = 1'b1;
        done  = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_async gnt=%h busy=%b idx=%0d to=%b want 00 0 0 0",
                     gnt, busy, gnt_idx, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle gnt=%h busy=%b idx=%0d to=%b want 00 0 0 0",
                     gnt, busy, gnt_idx, timeout);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h04;
        tick();
        checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant gnt=%h idx=%0d busy=%b want 04 2 1",
                     gnt, gnt_idx, busy);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 3'd2) begin
            errors++;
            $display("FAIL single_release gnt=%h busy=%b to=%b idx=%0d want 00 0 0 2",
                     gnt, busy, timeout, gnt_idx);
        end
        req = 8'h09;
        tick();
        checks++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
            errors++;
            $display("FAIL single_ptr3 gnt=%h idx=%0d want 08 3", gnt, gnt_idx);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_withdraw gnt=%h busy=%b to=%b want 00 0 0",
                     gnt, busy, timeout);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_idx;
        logic [7:0] exp_gnt;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_idx = 3'(k % 8);
            exp_gnt = 8'h01 << exp_idx;
            tick();
            checks++;
            if (gnt_idx !== exp_idx || gnt !== exp_gnt || busy !== 1'b1) begin
                errors++;
                $display("FAIL rot_grant%0d idx=%0d gnt=%h busy=%b want %0d %h 1",
                         k, gnt_idx, gnt, busy, exp_idx, exp_gnt);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt !== 8'h00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rot_idle%0d gnt=%h busy=%b want 00 0", k, gnt, busy);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h20;
        tick();
        req = 8'h00;
        tick();
        req = 8'h03;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL wrap gnt=%h idx=%0d want 01 0", gnt, gnt_idx);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        en  = 1'b0;
        req = 8'h01;
        tick();
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_gate gnt=%h busy=%b want 00 0", gnt, busy);
        end
        en = 1'b1;
        tick();
        en  = 1'b0;
        req = 8'h03;
        tick();
        checks++;
        if (gnt !== 8'h01 || busy !== 1'b1 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL en_hold gnt=%h busy=%b idx=%0d want 01 1 0",
                     gnt, busy, gnt_idx);
        end
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_idle gnt=%h busy=%b want 00 0", gnt, busy);
        end
        en  = 1'b1;
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h01;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h01 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold%0d gnt=%h to=%b want 01 0", c, gnt, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse gnt=%h to=%b busy=%b want 00 1 0",
                     gnt, timeout, busy);
        end
        tick();
        checks++;
        if (timeout !== 1'b0 || gnt !== 8'h01) begin
            errors++;
            $display("FAIL to_regrant to=%b gnt=%h want 0 01", timeout, gnt);
        end
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 8'h01) begin
            errors++;
            $display("FAIL to_cycle4 gnt=%h want 01", gnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_done_prec gnt=%h to=%b want 00 0", gnt, timeout);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'h10;
        tick();
        checks++;
        if (gnt !== 8'h10) begin
            errors++;
            $display("FAIL mr_grant gnt=%h want 10", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mr_drop gnt=%h busy=%b want 00 0", gnt, busy);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt_idx !== 3'd4 || gnt !== 8'h10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mr_regrant idx=%0d gnt=%h busy=%b want 4 10 1",
                     gnt_idx, gnt, busy);
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_enable();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
